// File: rtl/fp_adder_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// fp_adder_arbiter_pkg
//   Shared types for the floating-point adder arbiter: the 32-bit float word,
//   the width of the adder flag bundle, and the flag bundle itself.
//   No ports (package).
// ---------------------------------------------------------------------------
package fp_adder_arbiter_pkg;

    // IEEE-754 single precision word, treated as opaque bits by the arbiter.
    typedef logic [31:0] float;

    localparam int FPARB_FLAGS_W = 3;

    // Field order gives the packed layout {zero, inf, nan}, MSB first.
    typedef struct packed {
        logic zero;
        logic inf;
        logic nan;
    } fparb_flags_t;

endpackage : fp_adder_arbiter_pkg

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin pick. The winner is the first asserted bit of
//   valid_i at or after ptr_i, wrapping modulo NUM_REQ.
//   Ports:
//     valid_i  [NUM_REQ-1:0]  request vector
//     ptr_i    [IDX_W-1:0]    highest-priority index (must be < NUM_REQ)
//     grant_o  [NUM_REQ-1:0]  one-hot winner, zero when nothing is valid
//     idx_o    [IDX_W-1:0]    encoded winner, zero when nothing is valid
//     any_o                   at least one request is valid
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;

    // NOTE: every variable assigned in this block gets a default first, so no
    // path through the loop can leave it unassigned and infer a latch.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        sum     = '0;
        cand    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // One extra bit so ptr + offset cannot overflow before the wrap.
            sum = {1'b0, ptr_i} + (IDX_W + 1)'(i);
            if (sum >= (IDX_W + 1)'(NUM_REQ)) begin
                sum = sum - (IDX_W + 1)'(NUM_REQ);
            end
            cand = sum[IDX_W-1:0];
            if (!any_o && valid_i[cand]) begin
                any_o         = 1'b1;
                idx_o         = cand;
                grant_o[cand] = 1'b1;
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/fp_adder_arbiter.sv
// ---------------------------------------------------------------------------
// fp_adder_arbiter
//   Shares one floating-point adder among NUM_REQ requesters. A round-robin
//   winner is granted in IDLE, its operands are held stable on the adder
//   while Go is pulsed, and the result plus flags are returned to the owner.
//   Only one operation is in flight at a time.
//
//   Optional build macro FPARB_TIMEOUT_EN: aborts WAIT after TIMEOUT_CYCLES
//   cycles without Ready and returns a zero result with resp_timeout_o=1.
//   Without it WAIT is unbounded and resp_timeout_o is tied low.
//
//   Ports:
//     clk, rst_n                  clock, asynchronous active-low reset
//     req_valid_i  [NUM_REQ]      per-requester request, held until granted
//     req_a_i/req_b_i [NUM_REQ][32] per-requester operands
//     req_grant_o  [NUM_REQ]      one-hot pulse, operands captured this cycle
//     resp_valid_o [NUM_REQ]      one-hot pulse, response for that requester
//     resp_result_o[32]           result, held between responses
//     resp_flags_o [3]            {zero, inf, nan}, held between responses
//     resp_timeout_o              abort indicator, held between responses
//     add_a_o/add_b_o [32]        adder operands
//     add_go_o                    adder start pulse
//     add_result_i, add_ready_i, add_zero_i, add_inf_i, add_nan_i  adder outputs
// ---------------------------------------------------------------------------
module fp_adder_arbiter
    import fp_adder_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ-1:0][31:0]      req_a_i,
    input  logic [NUM_REQ-1:0][31:0]      req_b_i,
    output logic [NUM_REQ-1:0]            req_grant_o,
    output logic [NUM_REQ-1:0]            resp_valid_o,
    output logic [31:0]                   resp_result_o,
    output logic [FPARB_FLAGS_W-1:0]      resp_flags_o,
    output logic                          resp_timeout_o,
    output logic [31:0]                   add_a_o,
    output logic [31:0]                   add_b_o,
    output logic                          add_go_o,
    input  logic [31:0]                   add_result_i,
    input  logic                          add_ready_i,
    input  logic                          add_zero_i,
    input  logic                          add_inf_i,
    input  logic                          add_nan_i
);

    localparam int IDX_W = $clog2(NUM_REQ);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_HOLD  = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    float             op_a_q, op_a_d;
    float             op_b_q, op_b_d;
    float             res_q, res_d;
    fparb_flags_t     flags_q, flags_d;

`ifdef FPARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tmo_q, tmo_d;
`else
    // Parameter kept in the interface so both builds share one instantiation.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

    logic [NUM_REQ-1:0] arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .valid_i (req_valid_i),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .any_o   (arb_any)
    );

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        res_d   = res_q;
        flags_d = flags_q;
`ifdef FPARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (arb_any) begin
                    op_a_d  = req_a_i[arb_idx];
                    op_b_d  = req_b_i[arb_idx];
                    owner_d = arb_idx;
                    ptr_d   = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + IDX_W'(1);
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_HOLD;
            S_HOLD: begin
                // Ready seen here may belong to the previous op; it is ignored.
                state_d = S_WAIT;
`ifdef FPARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            S_WAIT: begin
                if (add_ready_i) begin
                    res_d   = add_result_i;
                    flags_d = '{zero: add_zero_i, inf: add_inf_i, nan: add_nan_i};
                    state_d = S_RESP;
`ifdef FPARB_TIMEOUT_EN
                    tmo_d   = 1'b0;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    // Ready has priority: this branch is only reached without it.
                    res_d   = '0;
                    flags_d = '0;
                    tmo_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
`endif
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            res_q   <= '0;
            flags_q <= '0;
`ifdef FPARB_TIMEOUT_EN
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            res_q   <= res_d;
            flags_q <= flags_d;
`ifdef FPARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
`endif
        end
    end

    logic operands_live;
    assign operands_live = (state_q == S_ISSUE) || (state_q == S_HOLD) || (state_q == S_WAIT);

    // Grant is combinational from IDLE; gating with rst_n keeps it low while
    // reset is held even if requests are pending.
    assign req_grant_o   = (rst_n && state_q == S_IDLE) ? arb_grant : '0;
    assign add_go_o      = (state_q == S_ISSUE);
    assign add_a_o       = operands_live ? op_a_q : '0;
    assign add_b_o       = operands_live ? op_b_q : '0;
    assign resp_valid_o  = (state_q == S_RESP) ? (NUM_REQ'(1) << owner_q) : '0;
    assign resp_result_o = res_q;
    assign resp_flags_o  = flags_q;
`ifdef FPARB_TIMEOUT_EN
    assign resp_timeout_o = tmo_q;
`else
    assign resp_timeout_o = 1'b0;
`endif

endmodule : fp_adder_arbiter

// File: tb/tb_fp_adder_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fp_adder_arbiter
//   Directed bench for fp_adder_arbiter with a behavioural adder model.
//   Stimulus pushes expected responses into a scoreboard queue; a monitor
//   pops and compares whenever resp_valid_o is seen.
// ---------------------------------------------------------------------------
module tb_fp_adder_arbiter;
    import fp_adder_arbiter_pkg::*;

    localparam int NUM_REQ = 4;
`ifdef FPARB_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 64;
`endif

    logic                     clk;
    logic                     rst_n;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0][31:0] req_a, req_b;
    logic [NUM_REQ-1:0]       req_grant_o, resp_valid_o;
    logic [31:0]              resp_result_o;
    logic [2:0]               resp_flags_o;
    logic                     resp_timeout_o;
    logic [31:0]              add_a_o, add_b_o;
    logic                     add_go_o;
    logic [31:0]              add_result;
    logic                     add_ready, add_zero, add_inf, add_nan;

    fp_adder_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid_i    (req_valid),
        .req_a_i        (req_a),
        .req_b_i        (req_b),
        .req_grant_o    (req_grant_o),
        .resp_valid_o   (resp_valid_o),
        .resp_result_o  (resp_result_o),
        .resp_flags_o   (resp_flags_o),
        .resp_timeout_o (resp_timeout_o),
        .add_a_o        (add_a_o),
        .add_b_o        (add_b_o),
        .add_go_o       (add_go_o),
        .add_result_i   (add_result),
        .add_ready_i    (add_ready),
        .add_zero_i     (add_zero),
        .add_inf_i      (add_inf),
        .add_nan_i      (add_nan)
    );

    typedef struct {
        int          idx;
        logic [31:0] res;
        logic [2:0]  flags;
        logic        tmo;
        int          lat;
    } exp_t;

    typedef struct {
        int idx;
        int cyc;
    } gnt_t;

    exp_t sb[$];
    gnt_t gq[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    // Adder model controls.
    int   lat         = 3;
    logic stale_mode  = 1'b0;
    logic never_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Hand-computed single-precision sums, {flags, result}; flags = {zero,inf,nan}.
    function automatic logic [34:0] model_add(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            64'h3FC00000_40100000: return {3'b000, 32'h40700000}; // 1.5 + 2.25
            64'h3F800000_3F800000: return {3'b000, 32'h40000000}; // 1 + 1
            64'h40000000_40000000: return {3'b000, 32'h40800000}; // 2 + 2
            64'h3F000000_3F000000: return {3'b000, 32'h3F800000}; // 0.5 + 0.5
            64'h7FC00000_3F800000: return {3'b001, 32'h7FC00000}; // NaN + 1
            64'h40800000_40800000: return {3'b000, 32'h41000000}; // 4 + 4
            64'h7F7FFFFF_7F7FFFFF: return {3'b010, 32'h7F800000}; // max + max
            64'h80000000_00000000: return {3'b100, 32'h00000000}; // -0 + +0
            default:               return {3'b111, 32'hDEADBEEF};
        endcase
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Adder model: samples Go at negedge, updates its outputs just after the
    // next posedge. Genuine Ready appears in WAIT cycle number 'lat'. In
    // stale_mode Ready is also high while idle and for one cycle after Go.
    initial begin
        logic        go_s, busy, genuine;
        logic [31:0] a_s, b_s, res;
        logic [2:0]  fl;
        int          cnt;
        busy = 1'b0; cnt = 0; res = '0; fl = '0;
        add_ready = 1'b0; add_result = '0; add_zero = 1'b0; add_inf = 1'b0; add_nan = 1'b0;
        forever begin
            @(negedge clk);
            go_s = add_go_o;
            a_s  = add_a_o;
            b_s  = add_b_o;
            @(posedge clk);
            #1;
            if (!rst_n) begin
                busy = 1'b0;
                cnt  = 0;
            end else if (go_s) begin
                busy      = 1'b1;
                cnt       = 1;
                {fl, res} = model_add(a_s, b_s);
            end else if (busy) begin
                cnt++;
                if (cnt > lat + 1) busy = 1'b0;
            end
            genuine    = busy && !never_ready && (cnt == lat + 1);
            add_ready  = genuine || (stale_mode && (!busy || cnt == 1));
            add_result = genuine ? res : 32'hBAD0BAD0;
            {add_zero, add_inf, add_nan} = genuine ? fl : 3'b111;
        end
    end

    // Monitor: grants, Go pulse width, and scoreboard comparison of responses.
    initial begin
        logic prev_go;
        exp_t e;
        gnt_t g;
        prev_go = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                gq.delete();
                prev_go = 1'b0;
            end else begin
                if (req_grant_o != '0) begin
                    check("grant_onehot", 32'($onehot(req_grant_o)), 32'd1);
                    g.idx = $clog2(req_grant_o);
                    g.cyc = cyc;
                    gq.push_back(g);
                end
                if (add_go_o) check("go_single_cycle", {31'd0, prev_go}, 32'd0);
                prev_go = add_go_o;
                if (resp_valid_o != '0) begin
                    if (sb.size() == 0) begin
                        check("unexpected_resp", {28'd0, resp_valid_o}, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("resp_valid", {28'd0, resp_valid_o}, 32'd1 << e.idx);
                        check("resp_result", resp_result_o, e.res);
                        check("resp_flags", {29'd0, resp_flags_o}, {29'd0, e.flags});
                        check("resp_timeout", {31'd0, resp_timeout_o}, {31'd0, e.tmo});
                        if (gq.size() == 0) begin
                            check("grant_missing", 32'd0, 32'd1);
                        end else begin
                            g = gq.pop_front();
                            check("grant_idx", g.idx, e.idx);
                            check("latency", cyc - g.cyc, e.lat);
                        end
                    end
                end
            end
        end
    end

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[i] = a;
        req_b[i] = b;
    endtask

    task automatic push_exp(input int idx, input logic [31:0] res, input logic [2:0] flags,
                            input logic tmo, input int latency);
        exp_t e;
        e.idx = idx; e.res = res; e.flags = flags; e.tmo = tmo; e.lat = latency;
        sb.push_back(e);
    endtask

    // Raise the requests in 'mask' and drop each one after the edge that
    // granted it. Called just after a posedge.
    task automatic issue(input logic [NUM_REQ-1:0] mask);
        logic [NUM_REQ-1:0] pending, g;
        pending   = mask;
        req_valid = req_valid | mask;
        for (int i = 0; i < 100 && pending != '0; i++) begin
            @(negedge clk);
            g = req_grant_o;
            @(posedge clk);
            #1;
            req_valid = req_valid & ~g;
            pending   = pending & ~g;
        end
        check("grant_timeout", {28'd0, pending}, 32'd0);
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && sb.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        #1;
        check("drain", sb.size(), 32'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_grant"},   {28'd0, req_grant_o},  32'd0);
        check({tag, "_rvalid"},  {28'd0, resp_valid_o}, 32'd0);
        check({tag, "_result"},  resp_result_o,         32'd0);
        check({tag, "_flags"},   {29'd0, resp_flags_o}, 32'd0);
        check({tag, "_timeout"}, {31'd0, resp_timeout_o}, 32'd0);
        check({tag, "_add_a"},   add_a_o,               32'd0);
        check({tag, "_add_b"},   add_b_o,               32'd0);
        check({tag, "_go"},      {31'd0, add_go_o},     32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Single add, Ready in the third WAIT cycle -> response 6 cycles after grant.
        lat = 3;
        set_op(0, 32'h3FC00000, 32'h40100000);
        push_exp(0, 32'h40700000, 3'b000, 1'b0, 6);
        issue(4'b0001);
        drain();

        // All four contend; pointer is 1 after the first grant, so the order
        // is 1,2,3,0 here; the 0..3 order is checked after a pointer wrap.
        lat = 2;
        set_op(0, 32'h3F800000, 32'h3F800000);
        set_op(1, 32'h40000000, 32'h40000000);
        set_op(2, 32'h3F000000, 32'h3F000000);
        set_op(3, 32'h7FC00000, 32'h3F800000);
        push_exp(1, 32'h40800000, 3'b000, 1'b0, 5);
        push_exp(2, 32'h3F800000, 3'b000, 1'b0, 5);
        push_exp(3, 32'h7FC00000, 3'b001, 1'b0, 5);
        push_exp(0, 32'h40000000, 3'b000, 1'b0, 5);
        issue(4'b1111);
        drain();

        // Pointer now 1; bring it to 0 with a lone grant of requester 3.
        set_op(3, 32'h3FC00000, 32'h40100000);
        push_exp(3, 32'h40700000, 3'b000, 1'b0, 5);
        issue(4'b1000);
        drain();

        // Pointer 0, all four held -> 0,1,2,3.
        set_op(3, 32'h7FC00000, 32'h3F800000);
        push_exp(0, 32'h40000000, 3'b000, 1'b0, 5);
        push_exp(1, 32'h40800000, 3'b000, 1'b0, 5);
        push_exp(2, 32'h3F800000, 3'b000, 1'b0, 5);
        push_exp(3, 32'h7FC00000, 3'b001, 1'b0, 5);
        issue(4'b1111);
        drain();

        // Pointer 0 again, requesters 0 and 3 -> 0 then 3.
        set_op(0, 32'h40800000, 32'h40800000);
        set_op(3, 32'h3FC00000, 32'h40100000);
        push_exp(0, 32'h41000000, 3'b000, 1'b0, 5);
        push_exp(3, 32'h40700000, 3'b000, 1'b0, 5);
        issue(4'b1001);
        drain();

        // Flags: overflow to +Inf, and signed zero sum.
        lat = 1;
        set_op(2, 32'h7F7FFFFF, 32'h7F7FFFFF);
        push_exp(2, 32'h7F800000, 3'b010, 1'b0, 4);
        issue(4'b0100);
        drain();
        set_op(1, 32'h80000000, 32'h00000000);
        push_exp(1, 32'h00000000, 3'b100, 1'b0, 4);
        issue(4'b0010);
        drain();

        // Stale Ready: high while idle and through HOLD; genuine Ready in WAIT cycle 4.
        stale_mode = 1'b1;
        lat        = 4;
        set_op(1, 32'h3FC00000, 32'h40100000);
        push_exp(1, 32'h40700000, 3'b000, 1'b0, 7);
        issue(4'b0010);
        drain();
        stale_mode = 1'b0;

`ifdef FPARB_TIMEOUT_EN
        // No Ready at all: abort after 16 WAIT cycles, then a normal op.
        never_ready = 1'b1;
        set_op(3, 32'h3F800000, 32'h3F800000);
        push_exp(3, 32'h00000000, 3'b000, 1'b1, 3 + TMO);
        issue(4'b1000);
        drain();
        never_ready = 1'b0;
        lat = 3;
        set_op(0, 32'h40000000, 32'h40000000);
        push_exp(0, 32'h40800000, 3'b000, 1'b0, 6);
        issue(4'b0001);
        drain();
`endif

        // Reset during WAIT: op from requester 2 (pointer -> 3) is discarded.
        lat = 20;
        set_op(2, 32'h3F800000, 32'h3F800000);
        issue(4'b0100);
        repeat (3) @(posedge clk);
        set_op(1, 32'h40000000, 32'h40000000);
        set_op(3, 32'h3F000000, 32'h3F000000);
        req_valid = 4'b1010;
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midwait_reset");
        repeat (2) @(posedge clk);
        #2;
        lat = 3;
        push_exp(1, 32'h40800000, 3'b000, 1'b0, 6);
        push_exp(3, 32'h3F800000, 3'b000, 1'b0, 6);
        rst_n = 1'b1;
        issue(4'b1010);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fp_adder_arbiter
